// File: rtl/snn_noc_pkg.sv
// Shared definitions for the spiking-network fabric: default widths,
// configuration table selects and the fanout FSM state encoding.
package snn_noc_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int PTR_W_DEF  = 14;

    typedef enum logic [1:0] {
        CFG_SEL_ADDR = 2'b00,
        CFG_SEL_PTR  = 2'b01,
        CFG_SEL_CONN = 2'b10,
        CFG_SEL_RSVD = 2'b11
    } cfg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EMIT = 2'b10
    } fanout_state_e;

    // Index width for a table of 'depth' entries, never below one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spike_priority_picker.sv
// Selects the lowest-index set bit of a request vector.
module spike_priority_picker
    import snn_noc_pkg::*;
#(
    parameter int N     = 10,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Scanning downwards leaves the lowest set bit as the final winner.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spike_fanout_engine.sv
// Latches incoming spikes and expands each pending source neuron into one
// packet per downstream connection, lowest neuron index first.
module spike_fanout_engine
    import snn_noc_pkg::*;
#(
    parameter int NUM_NEURONS     = 10,
    parameter int MAX_CONNECTIONS = 30,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int PTR_W           = PTR_W_DEF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [PTR_W-1:0]       cfg_index,
    input  logic [PTR_W-1:0]       cfg_data,
    output logic                   cfg_err,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [ADDR_W-1:0]      pkt_src,
    output logic [ADDR_W-1:0]      pkt_dst,
    output logic                   busy,
    output logic [7:0]             merge_count
);

    localparam int NIDX_W = idx_width(NUM_NEURONS);
    localparam int PIDX_W = idx_width(NUM_NEURONS + 1);
    localparam int CIDX_W = idx_width(MAX_CONNECTIONS);
    localparam logic [PTR_W-1:0] MAX_CONN_P = PTR_W'(MAX_CONNECTIONS);

    logic [ADDR_W-1:0] addr_tbl_q [NUM_NEURONS];
    logic [PTR_W-1:0]  ptr_tbl_q  [NUM_NEURONS+1];
    logic [ADDR_W-1:0] conn_tbl_q [MAX_CONNECTIONS];

    fanout_state_e            state_q, state_d;
    logic [NUM_NEURONS-1:0]   pending_q, pending_d;
    logic [7:0]               merge_q, merge_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     pkt_valid_q, pkt_valid_d;
    logic [ADDR_W-1:0]        pkt_src_q, pkt_src_d;
    logic [ADDR_W-1:0]        pkt_dst_q, pkt_dst_d;
    logic [PTR_W-1:0]         j_q, j_d;
    logic [PTR_W-1:0]         end_q, end_d;
    logic [NIDX_W-1:0]        n_q, n_d;

    logic                     pick_valid;
    logic [NIDX_W-1:0]        pick_idx;
    logic [NUM_NEURONS-1:0]   clr_mask;
    logic [NUM_NEURONS-1:0]   merged;
    logic [PTR_W-1:0]         start_ptr, next_ptr, end_val, j_inc;
    logic                     cfg_in_range, cfg_accept;
    int unsigned              merge_sum;

    spike_priority_picker #(
        .N     (NUM_NEURONS),
        .IDX_W (NIDX_W)
    ) u_picker (
        .req   (pending_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign busy        = (state_q != ST_IDLE) || (|pending_q);
    assign cfg_err     = cfg_err_q;
    assign pkt_valid   = pkt_valid_q;
    assign pkt_src     = pkt_src_q;
    assign pkt_dst     = pkt_dst_q;
    assign merge_count = merge_q;

    assign start_ptr = ptr_tbl_q[PIDX_W'(n_q)];
    assign next_ptr  = ptr_tbl_q[PIDX_W'(n_q) + PIDX_W'(1)];
    assign end_val   = (next_ptr > MAX_CONN_P) ? MAX_CONN_P : next_ptr;
    assign j_inc     = j_q + PTR_W'(1);

    // Table writes are only safe while no fanout can be reading them.
    always_comb begin
        unique case (cfg_sel)
            CFG_SEL_ADDR: cfg_in_range = cfg_index < PTR_W'(NUM_NEURONS);
            CFG_SEL_PTR:  cfg_in_range = cfg_index < PTR_W'(NUM_NEURONS + 1);
            CFG_SEL_CONN: cfg_in_range = cfg_index < MAX_CONN_P;
            default:      cfg_in_range = 1'b0;
        endcase
        cfg_accept = cfg_we && !busy && !clear && cfg_in_range;
        cfg_err_d  = cfg_we && !cfg_accept;
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        j_d         = j_q;
        end_d       = end_q;
        pkt_valid_d = pkt_valid_q;
        pkt_src_d   = pkt_src_q;
        pkt_dst_d   = pkt_dst_q;
        clr_mask    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    n_d     = pick_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (start_ptr >= end_val) begin
                    clr_mask[n_q] = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    j_d         = start_ptr;
                    end_d       = end_val;
                    pkt_src_d   = addr_tbl_q[n_q];
                    pkt_dst_d   = conn_tbl_q[start_ptr[CIDX_W-1:0]];
                    pkt_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (pkt_ready) begin
                    if (j_q == end_q - PTR_W'(1)) begin
                        clr_mask[n_q] = 1'b1;
                        pkt_valid_d   = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        // Prefetch the next destination so packets stream back to back.
                        j_d       = j_inc;
                        pkt_dst_d = conn_tbl_q[j_inc[CIDX_W-1:0]];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A spike on a bit retired this cycle starts a fresh fanout, not a merge.
        merged    = spike_in & pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | spike_in;
        merge_sum = 32'(merge_q);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            merge_sum = merge_sum + 32'(merged[i]);
        end
        merge_d = (merge_sum > 32'd255) ? 8'hFF : merge_sum[7:0];

        if (clear) begin
            pending_d   = '0;
            merge_d     = merge_q;
            pkt_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            merge_q     <= '0;
            cfg_err_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_src_q   <= '0;
            pkt_dst_q   <= '0;
            j_q         <= '0;
            end_q       <= '0;
            n_q         <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            merge_q     <= merge_d;
            cfg_err_q   <= cfg_err_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_src_q   <= pkt_src_d;
            pkt_dst_q   <= pkt_dst_d;
            j_q         <= j_d;
            end_q       <= end_d;
            n_q         <= n_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                addr_tbl_q[i] <= ADDR_W'(i);
            end
            for (int i = 0; i < NUM_NEURONS + 1; i++) begin
                ptr_tbl_q[i] <= '0;
            end
            for (int i = 0; i < MAX_CONNECTIONS; i++) begin
                conn_tbl_q[i] <= '0;
            end
        end else if (cfg_accept) begin
            unique case (cfg_sel)
                CFG_SEL_ADDR: addr_tbl_q[cfg_index[NIDX_W-1:0]] <= cfg_data[ADDR_W-1:0];
                CFG_SEL_PTR:  ptr_tbl_q[cfg_index[PIDX_W-1:0]]  <= cfg_data;
                CFG_SEL_CONN: conn_tbl_q[cfg_index[CIDX_W-1:0]] <= cfg_data[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spike_fanout_engine.md
SPIKE_FANOUT_ENGINE -- requirements
Module: spike_fanout_engine

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, number of local source neurons.
REQ-002 SHALL have parameter MAX_CONNECTIONS, default 30, depth of the downstream connection table.
REQ-003 SHALL have parameter ADDR_W, default 12, neuron address width.
REQ-004 SHALL have parameter PTR_W, default 14, connection pointer width.
REQ-005 SHALL have port CLK, input, 1, the single clock.
REQ-006 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have port clear, input, 1, timestep clear; flushes pending spikes.
REQ-008 SHALL have port spike_in, input, NUM_NEURONS, per-neuron spike pulses.
REQ-009 SHALL have port cfg_we, input, 1, configuration table write strobe.
REQ-010 SHALL have port cfg_sel, input, 2, table select: 00 address, 01 pointer, 10 connection, 11 reserved.
REQ-011 SHALL have port cfg_index, input, PTR_W, table entry index.
REQ-012 SHALL have port cfg_data, input, PTR_W, write data; tables of ADDR_W width use the low ADDR_W bits.
REQ-013 SHALL have port cfg_err, output, 1, one-cycle pulse when a write is rejected.
REQ-014 SHALL have port pkt_valid, output, 1, packet available.
REQ-015 SHALL have port pkt_ready, input, 1, downstream accepts the packet.
REQ-016 SHALL have port pkt_src, output, ADDR_W, source neuron address.
REQ-017 SHALL have port pkt_dst, output, ADDR_W, destination neuron address.
REQ-018 SHALL have port busy, output, 1, high when the FSM is not in IDLE or any pending bit is set.
REQ-019 SHALL have port merge_count, output, 8, saturating count of merged spikes.

Function
REQ-020 SHALL sample spike_in every cycle and OR it into a pending register (pending |= spike_in).
REQ-021 SHALL increment merge_count when a spike_in bit arrives whose pending bit is already set and is not being cleared that cycle; it saturates at 255.
REQ-022 SHALL use FSM states IDLE, LOAD and EMIT.
REQ-023 IDLE SHALL select the lowest-index pending neuron n, latch n, and go to LOAD.
REQ-024 LOAD SHALL read start=ptr[n] and end=min(ptr[n+1], MAX_CONNECTIONS); if start>=end it SHALL clear pending[n] and return to IDLE with no packet, otherwise set j=start and go to EMIT.
REQ-025 EMIT SHALL drive pkt_valid=1, pkt_src=addr[n] and pkt_dst=conn[j].
REQ-026 In EMIT, a handshake SHALL occur on pkt_valid&&pkt_ready; on each handshake j increments, and the handshake with j==end-1 SHALL clear pending[n] and return to IDLE.
REQ-027 pkt_valid, pkt_src and pkt_dst SHALL hold stable while pkt_ready is low.
REQ-028 The first pkt_valid SHALL appear 2 cycles after the edge that samples the spike; with pkt_ready held high, throughput SHALL be 1 packet per cycle.
REQ-029 clear=1 SHALL zero pending, abort any in-progress fanout, and force IDLE on the next edge; spike_in sampled in the same cycle is discarded.
REQ-030 Spikes on neurons other than n during EMIT SHALL only set pending bits and SHALL not preempt n.
REQ-031 cfg_we SHALL be accepted only when busy=0, clear=0, cfg_sel!=11 and cfg_index is in range; otherwise the table SHALL be unchanged and cfg_err SHALL pulse the next cycle.
REQ-032 The pointer table SHALL have NUM_NEURONS+1 entries, the address table NUM_NEURONS entries, and the connection table MAX_CONNECTIONS entries.

Reset
REQ-033 RESET SHALL clear pending, merge_count, cfg_err, pkt_valid, pkt_src, pkt_dst, j and n, and set the FSM to IDLE.
REQ-034 RESET SHALL set addr[i]=i, all pointers to 0 and all connections to 0.
REQ-035 RESET SHALL take priority over clear and cfg_we.

Structure
REQ-036 A shared package snn_noc_pkg SHALL hold the default ADDR_W/PTR_W, the cfg_sel encodings and the FSM state enum.
REQ-037 The lowest-index pending selection SHALL be a sub-module spike_priority_picker (NUM_NEURONS-wide; outputs valid and index).

Verification
REQ-038 Program 10-neuron table (ptr 0,3,5,8,10,12,14,15,17,18,19; neuron0 -> 3,5,7), pulse spike_in[0], pkt_ready=1 -> packets (0,3),(0,5),(0,7) on consecutive cycles, first 2 cycles after sampling, then busy=0.
REQ-039 Same spike with pkt_ready low for 4 cycles -> (0,3) held stable, then the sequence completes with no loss or duplicate.
REQ-040 spike_in[8] and [3] in the same cycle -> all neuron 3 packets (3,4),(3,6) precede neuron 8's (8,0xFFB).
REQ-041 Neuron with ptr[n]==ptr[n+1] spiking -> no pkt_valid, pending cleared within 2 cycles.
REQ-042 Assert clear mid-EMIT of neuron 0 -> pkt_valid low next cycle and pending==0; re-spike restarts from (0,3).
REQ-043 cfg_we while busy, and cfg_sel=11 -> tables unchanged, cfg_err pulses; spike[2] twice during fanout -> merge_count=1.
